mdu_div_sched: RTL

Two-port scheduler that shares the single iterative divider in the MDU between two issue pipes. Each cycle in which the divider is free it accepts at most one request by round-robin arbitration, registers the operands, and pulses the divider start. It then tracks the divider busy flag, selects the quotient or remainder, and holds the tagged result until writeback accepts it. It also handles pipeline flush for an operation already in flight.

---
 rtl/mdu_div_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mdu_div_sched.sv
// mdu_div_sched: round-robin scheduler sharing one iterative divider between two issue pipes.
// Accepts one operation at a time, tracks divider busy, and holds the tagged result for writeback.
`ifndef _MDU_DIV
`define _MDU_DIV  3'd4
`endif
`ifndef _MDU_DIVU
`define _MDU_DIVU 3'd5
`endif
`ifndef _MDU_MOD
`define _MDU_MOD  3'd6
`endif
`ifndef _MDU_MODU
`define _MDU_MODU 3'd7
`endif
`ifndef ARF_WIDTH
`define ARF_WIDTH 5
`endif

module mdu_div_sched #(
  parameter int DATA_W = 32,
  parameter int SRC_N  = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [SRC_N-1:0]                    req_valid_i,
  output logic [SRC_N-1:0]                    req_ready_o,
  input  logic [SRC_N-1:0][2:0]               req_op_i,
  input  logic [SRC_N-1:0][DATA_W-1:0]        req_data0_i,
  input  logic [SRC_N-1:0][DATA_W-1:0]        req_data1_i,
  input  logic [SRC_N-1:0][`ARF_WIDTH-1:0]    req_wid_i,
  output logic                                div_start_o,
  output logic [DATA_W-1:0]                   div_num0_o,
  output logic [DATA_W-1:0]                   div_num1_o,
  output logic                                div_sign_o,
  input  logic                                div_busy_i,
  input  logic [DATA_W-1:0]                   div_div_res_i,
  input  logic [DATA_W-1:0]                   div_mod_res_i,
  output logic                                res_valid_o,
  input  logic                                res_ready_i,
  output logic [DATA_W-1:0]                   res_data_o,
  output logic [`ARF_WIDTH-1:0]               res_wid_o,
  output logic                                res_src_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [2:0]              op_r;
  logic [DATA_W-1:0]       num0_r, num1_r, res_data_r;
  logic [`ARF_WIDTH-1:0]   wid_r;
  logic                    src_r, last_grant_r, sign_r;
  logic                    grant_s, accept_s, latch_res_s;
  logic [DATA_W-1:0]       res_sel_s;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == `_MDU_DIV) || (op == `_MDU_MOD);
  endfunction

  function automatic logic is_quot_op(input logic [2:0] op);
    return (op == `_MDU_DIV) || (op == `_MDU_DIVU);
  endfunction

  // Round-robin pick: the port not granted last time wins a tie.
  always_comb begin
    grant_s = 1'b0;
    if (req_valid_i[0] && req_valid_i[1]) begin
      grant_s = ~last_grant_r;
    end else if (req_valid_i[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s    = (state_r == S_IDLE) && !flush && (|req_valid_i);
  assign req_ready_o = accept_s ? (grant_s ? 2'b10 : 2'b01) : 2'b00;
  assign res_sel_s   = is_quot_op(op_r) ? div_div_res_i : div_mod_res_i;

  // Next-state and strobe decode; flush always outranks completion and handshake.
  always_comb begin
    state_s     = state_r;
    latch_res_s = 1'b0;
    div_start_o = 1'b0;
    res_valid_o = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_s = S_START;
        else          state_s = S_IDLE;
      end
      S_START: begin
        div_start_o = ~flush;
        if (flush) state_s = S_DRAIN;
        else       state_s = S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          state_s = S_DRAIN;
        end else if (!div_busy_i) begin
          latch_res_s = 1'b1;
          state_s     = S_DONE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DONE: begin
        res_valid_o = ~flush;
        if (flush)            state_s = S_IDLE;
        else if (res_ready_i) state_s = S_IDLE;
        else                  state_s = S_DONE;
      end
      S_DRAIN: begin
        // The divider cannot be aborted; let it finish before re-arbitrating.
        if (!div_busy_i) state_s = S_IDLE;
        else             state_s = S_DRAIN;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, operand capture on accept, and result capture on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      last_grant_r <= 1'b1;
      op_r         <= 3'd0;
      num0_r       <= '0;
      num1_r       <= '0;
      sign_r       <= 1'b0;
      wid_r        <= '0;
      src_r        <= 1'b0;
      res_data_r   <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_r         <= req_op_i[grant_s];
        num0_r       <= req_data0_i[grant_s];
        num1_r       <= req_data1_i[grant_s];
        sign_r       <= is_signed_op(req_op_i[grant_s]);
        wid_r        <= req_wid_i[grant_s];
        src_r        <= grant_s;
        last_grant_r <= grant_s;
      end
      if (latch_res_s) begin
        res_data_r <= res_sel_s;
      end
    end
  end

  assign div_num0_o = num0_r;
  assign div_num1_o = num1_r;
  assign div_sign_o = sign_r;
  assign res_data_o = res_data_r;
  assign res_wid_o  = wid_r;
  assign res_src_o  = src_r;

endmodule
